fifo_stream_reader: RTL and testbench
=====================================

Name: fifo_stream_reader

Overview:
- Downstream drain stage for the synchronous FIFO.
- Pulls words from the FIFO read port (rd_en / rdata / empty) and presents them on a valid/ready stream.
- Absorbs the FIFO's 1-cycle read latency with a 2-entry skid buffer, so there are no drops or duplicates under back-pressure.
- Frames the stream into fixed-length packets: a last flag on the final beat of each packet, plus a completed-packet counter.

Parameters:
- WIDTH, 8, data width; equals the FIFO data width.
- PKT_LEN, 4, beats per packet; must be >= 1.
- CNT_W, 16, width of the completed-packet counter.

Ports:
- clk_i  input  1  single clock; all logic on the rising edge.
- rst_i  input  1  synchronous active-low reset; 0 = reset, sampled on the rising edge of clk_i.
- fifo_empty_i  input  1  FIFO empty flag.
- fifo_rdata_i  input  WIDTH  FIFO read data; valid in the cycle after a cycle with fifo_rd_en_o=1 and fifo_empty_i=0.
- fifo_rd_en_o  output  1  FIFO read enable.
- m_valid_o  output  1  stream data valid.
- m_ready_i  input  1  downstream ready.
- m_data_o  output  WIDTH  stream data.
- m_last_o  output  1  final beat of the current packet.
- pkt_cnt_o  output  CNT_W  number of completed packets; wraps modulo 2^CNT_W.

Behaviour:
- Reset (rst_i=0 at an edge):
  - buffer occupancy, in-flight flag, beat counter and pkt_cnt_o cleared.
  - m_valid_o=0, m_data_o=0, m_last_o=0.
  - fifo_rd_en_o forced 0 while rst_i=0.
  - A read in flight when reset hits is discarded: its data is not captured.
- State:
  - occ: 0..2 words held.
  - infl: 1 if a FIFO read was issued at the previous edge.
  - beat: 0..PKT_LEN-1.
- Pop: pop = m_valid_o & m_ready_i.
- Read issue (combinational): fifo_rd_en_o = rst_i & ~fifo_empty_i & ((occ + infl - pop) < 2).
  - Never issue while the FIFO is empty, so the FIFO rd_error never fires.
- Capture:
  - When infl=1, fifo_rdata_i is written into the buffer at that edge.
  - Written at the head if the buffer is empty or the head is popping with no second entry; otherwise at the tail.
- Ordering: strict FIFO order, head presented on m_data_o.
- Same-cycle pop and capture: occ unchanged, head advances.
- m_valid_o = (occ != 0), registered.
- Throughput and latency:
  - With m_ready_i held high and the FIFO non-empty, sustained 1 beat/cycle.
  - First valid appears 2 edges after the first fifo_rd_en_o assertion.
- Stream rule: while m_valid_o=1 and m_ready_i=0, m_data_o and m_last_o hold stable and occ never exceeds 2.
- Framing:
  - m_last_o = m_valid_o & (beat == PKT_LEN-1).
  - On pop: beat increments; at PKT_LEN-1 it wraps to 0 and pkt_cnt_o increments.
  - PKT_LEN=1: every beat is last.
- FIFO empty mid-packet: m_valid_o drops once the buffer drains; beat holds; the packet resumes when data returns. No timeout, no padding.
- m_data_o when m_valid_o=0: holds the last value (don't-care for checking, but must not be X after reset).

Test Plan:
- Reset: assert rst_i=0 for 2 cycles with the FIFO non-empty -> fifo_rd_en_o=0, m_valid_o=0, m_data_o=0, m_last_o=0, pkt_cnt_o=0.
- Full-rate drain: FIFO preloaded with 8 words 0x11,0x22,...,0x88, m_ready_i=1 -> 8 consecutive beats in order; m_last_o on 0x44 and 0x88; pkt_cnt_o=2; fifo_rd_en_o high for exactly 8 cycles.
- Back-pressure: same preload, m_ready_i=0 -> exactly 2 reads issued; m_valid_o=1 with m_data_o=0x11 stable. Release ready -> remaining 8 beats in order, none lost.
- Toggled ready: m_ready_i pattern 1,0,1,0,... over 8 words -> output sequence 0x11..0x88 with no duplicates or drops; m_last_o only on beats 4 and 8.
- Underflow gap: FIFO supplies 3 words, stays empty 5 cycles, then 1 more -> m_valid_o low during the gap; 4th word (0x44) carries m_last_o; pkt_cnt_o=1. Continuously check that no fifo_rd_en_o occurs while fifo_empty_i=1.
- Mid-packet reset: reset after beat 2 of a packet with 2 words buffered -> buffered words dropped, pkt_cnt_o=0. Next word after reset is beat 0 and m_last_o first appears 4 beats later.

Source files
------------

// File: rtl/fifo_stream_reader.sv
// Drains a 1-cycle-latency synchronous FIFO into a valid/ready stream via a
// 2-entry skid buffer, framing beats into fixed-length packets.
module fifo_stream_reader #(
  parameter int WIDTH   = 8,
  parameter int PKT_LEN = 4,
  parameter int CNT_W   = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             fifo_empty_i,
  input  logic [WIDTH-1:0] fifo_rdata_i,
  output logic             fifo_rd_en_o,
  output logic             m_valid_o,
  input  logic             m_ready_i,
  output logic [WIDTH-1:0] m_data_o,
  output logic             m_last_o,
  output logic [CNT_W-1:0] pkt_cnt_o
);

  localparam int BW = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam logic [BW-1:0] BEAT_MAX = BW'(PKT_LEN - 1);

  logic [1:0]       occ_q, occ_d;
  logic             infl_q;
  logic             valid_q;
  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] tail_q, tail_d;
  logic [BW-1:0]    beat_q, beat_d;
  logic [CNT_W-1:0] pkt_q, pkt_d;
  logic             pop;
  logic [2:0]       level;

  assign pop   = valid_q & m_ready_i;
  // Words held plus the one in flight, minus the one leaving this edge.
  assign level = {1'b0, occ_q} + {2'b00, infl_q} - {2'b00, pop};

  assign fifo_rd_en_o = rst_i & ~fifo_empty_i & (level < 3'd2);
  assign m_valid_o    = valid_q;
  assign m_data_o     = head_q;
  assign m_last_o     = valid_q & (beat_q == BEAT_MAX);
  assign pkt_cnt_o    = pkt_q;

  always_comb begin
    occ_d  = occ_q;
    head_d = head_q;
    tail_d = tail_q;
    beat_d = beat_q;
    pkt_d  = pkt_q;

    case ({pop, infl_q})
      2'b11: begin
        if (occ_q == 2'd1) begin
          head_d = fifo_rdata_i;
        end else begin
          head_d = tail_q;
          tail_d = fifo_rdata_i;
        end
      end
      2'b10: begin
        // Keep the old head visible once the buffer drains to empty.
        if (occ_q == 2'd2) head_d = tail_q;
        occ_d = occ_q - 2'd1;
      end
      2'b01: begin
        if (occ_q == 2'd0) head_d = fifo_rdata_i;
        else               tail_d = fifo_rdata_i;
        occ_d = occ_q + 2'd1;
      end
      default: ;
    endcase

    if (pop) begin
      if (beat_q == BEAT_MAX) begin
        beat_d = '0;
        pkt_d  = pkt_q + 1'b1;
      end else begin
        beat_d = beat_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      occ_q   <= '0;
      infl_q  <= 1'b0;
      valid_q <= 1'b0;
      head_q  <= '0;
      tail_q  <= '0;
      beat_q  <= '0;
      pkt_q   <= '0;
    end else begin
      occ_q   <= occ_d;
      infl_q  <= fifo_rd_en_o;
      valid_q <= (occ_d != 2'd0);
      head_q  <= head_d;
      tail_q  <= tail_d;
      beat_q  <= beat_d;
      pkt_q   <= pkt_d;
    end
  end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench for fifo_stream_reader: behavioural FIFO with 1-cycle read
// latency, beats recorded at each sample point and compared to fixed tables.
module tb_fifo_stream_reader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fifo_empty;
  logic [7:0]  fifo_rdata = '0;
  logic        fifo_rd_en;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [7:0]  m_data;
  logic        m_last;
  logic [15:0] pkt_cnt;

  fifo_stream_reader #(.WIDTH(8), .PKT_LEN(4), .CNT_W(16)) dut (
    .clk_i        (clk),
    .rst_i        (rst_n),
    .fifo_empty_i (fifo_empty),
    .fifo_rdata_i (fifo_rdata),
    .fifo_rd_en_o (fifo_rd_en),
    .m_valid_o    (m_valid),
    .m_ready_i    (m_ready),
    .m_data_o     (m_data),
    .m_last_o     (m_last),
    .pkt_cnt_o    (pkt_cnt)
  );

  always #5 clk = ~clk;

  logic [7:0]  mem [0:63];
  int unsigned wr_ptr = 0;
  int unsigned rd_ptr = 0;
  logic [7:0]  pend [$];

  assign fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    if (fifo_rd_en && !fifo_empty) begin
      fifo_rdata <= mem[rd_ptr[5:0]];
      rd_ptr     <= rd_ptr + 1;
    end
  end

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int rd_cnt = 0;
  int empty_rd = 0;
  int first_rd = -1;
  int first_v = -1;
  logic [7:0] got_d [$];
  logic       got_l [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic push(input logic [7:0] d);
    pend.push_back(d);
  endtask

  task automatic clear_rec();
    got_d.delete();
    got_l.delete();
    rd_cnt   = 0;
    cyc      = 0;
    first_rd = -1;
    first_v  = -1;
  endtask

  // Drive inputs at the falling edge, then sample what the next rising edge will see.
  task automatic step(input logic rdy, input logic rstn);
    @(negedge clk);
    while (pend.size() != 0) begin
      mem[wr_ptr[5:0]] = pend.pop_front();
      wr_ptr = wr_ptr + 1;
    end
    m_ready = rdy;
    rst_n   = rstn;
    #1;
    if (fifo_rd_en && fifo_empty) empty_rd++;
    if (fifo_rd_en) begin
      rd_cnt++;
      if (first_rd < 0) first_rd = cyc;
    end
    if (m_valid && first_v < 0) first_v = cyc;
    if (m_valid && m_ready) begin
      got_d.push_back(m_data);
      got_l.push_back(m_last);
    end
    cyc++;
  endtask

  task automatic check_beats(input string tag, input logic [7:0] base, input int n);
    chk({tag, "_count"}, got_d.size(), n);
    for (int i = 0; i < n && i < got_d.size(); i++) begin
      chk({tag, "_data"}, got_d[i], base * 8'(i + 1));
      chk({tag, "_last"}, got_l[i], ((i % 4) == 3) ? 1 : 0);
    end
  endtask

  initial begin
    // Reset held with the FIFO loaded.
    for (int i = 1; i <= 8; i++) push(8'(8'h11 * i));
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    chk("rst_rd_en", fifo_rd_en, 0);
    chk("rst_valid", m_valid, 0);
    chk("rst_data", m_data, 0);
    chk("rst_last", m_last, 0);
    chk("rst_pkt", pkt_cnt, 0);

    // Full-rate drain.
    clear_rec();
    for (int i = 0; i < 14; i++) step(1'b1, 1'b1);
    check_beats("full", 8'h11, 8);
    chk("full_pkt", pkt_cnt, 2);
    chk("full_rd_cnt", rd_cnt, 8);
    chk("full_latency", first_v - first_rd, 2);

    // Back-pressure: only two reads, head held stable.
    clear_rec();
    for (int i = 1; i <= 8; i++) push(8'(8'h11 * i));
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b1);
      if (i >= 3) begin
        chk("bp_valid", m_valid, 1);
        chk("bp_hold", m_data, 8'h11);
        chk("bp_last", m_last, 0);
      end
    end
    chk("bp_rd_cnt", rd_cnt, 2);
    clear_rec();
    for (int i = 0; i < 12; i++) step(1'b1, 1'b1);
    check_beats("bp_rel", 8'h11, 8);
    chk("bp_pkt", pkt_cnt, 4);

    // Alternating ready.
    clear_rec();
    for (int i = 1; i <= 8; i++) push(8'(8'h11 * i));
    for (int i = 0; i < 24; i++) step((i % 2) == 0, 1'b1);
    check_beats("tog", 8'h11, 8);
    chk("tog_pkt", pkt_cnt, 6);

    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    chk("rst2_pkt", pkt_cnt, 0);

    // Underflow gap mid-packet.
    clear_rec();
    push(8'h11); push(8'h22); push(8'h33);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1);
    chk("gap_valid", m_valid, 0);
    chk("gap_count", got_d.size(), 3);
    chk("gap_pkt_hold", pkt_cnt, 0);
    push(8'h44);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1);
    check_beats("gap", 8'h11, 4);
    chk("gap_pkt", pkt_cnt, 1);

    // Reset after beat 2 with two words buffered.
    clear_rec();
    push(8'hA1); push(8'hA2); push(8'hA3); push(8'hA4);
    for (int i = 0; i < 10 && got_d.size() < 2; i++) step(1'b1, 1'b1);
    chk("mid_pops", got_d.size(), 2);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1);
    chk("mid_valid", m_valid, 1);
    chk("mid_head", m_data, 8'hA3);
    chk("mid_last", m_last, 0);
    step(1'b0, 1'b0);
    chk("mid_rst_rd_en", fifo_rd_en, 0);
    step(1'b0, 1'b0);
    chk("mid_rst_valid", m_valid, 0);
    chk("mid_rst_pkt", pkt_cnt, 0);
    chk("mid_rst_data", m_data, 0);
    clear_rec();
    push(8'h0B); push(8'h16); push(8'h21); push(8'h2C);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1);
    check_beats("post", 8'h0B, 4);
    chk("post_pkt", pkt_cnt, 1);

    chk("no_empty_read", empty_rd, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
